add_accumulator: RTL and testbench

Sequencing stage wrapped around the clocked 4-bit `adder`. It drives the adder's `ain`/`bin` inputs and consumes its `out` result. It accepts a stream of operand words over a valid/ready handshake and feeds each word to the adder together with a running accumulator. After the adder's fixed latency it captures the sum back into the accumulator. After `N_WORDS` operands it presents the batch total, plus a wrap flag, on a second valid/ready handshake.

---
 rtl/add_accumulator_if.sv | 24 ++
 rtl/add_accumulator.sv | 102 ++++++++++
 tb/tb_add_accumulator.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/add_accumulator_if.sv
// Operand and result handshakes between a stream source/sink and add_accumulator.
interface add_accumulator_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_wrap;
  logic             res_ready;

  // Stream source / result sink side.
  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_data, res_wrap
  );

  // add_accumulator side.
  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_data, res_wrap
  );
endinterface

// File: rtl/add_accumulator.sv
// Sequencing stage around an external clocked adder: feeds each operand with the
// running accumulator, captures the sum after ADD_LAT edges, and after N_WORDS
// operands presents the batch total and a wrap flag.
module add_accumulator #(
  parameter int WIDTH   = 4,
  parameter int ADD_LAT = 1,
  parameter int N_WORDS = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  add_accumulator_if.slave  bus,
  output logic [WIDTH-1:0]  ain,
  output logic [WIDTH-1:0]  bin,
  input  logic [WIDTH-1:0]  sum,
  output logic              busy
);

  localparam int         LCW  = (ADD_LAT < 1) ? 1 : $clog2(ADD_LAT + 1);
  localparam logic [3:0] LAST = 4'(N_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESULT} state_t;

  state_t           state_q,   state_d;
  logic [WIDTH-1:0] acc_q,     acc_d;
  logic [WIDTH-1:0] opnd_q,    opnd_d;
  logic [LCW-1:0]   lat_cnt_q, lat_cnt_d;
  logic [3:0]       count_q,   count_d;
  logic             wrap_q,    wrap_d;
  logic [3:0]       count_inc;

  // Next-state: accept in IDLE, count down adder latency then capture in WAIT,
  // hold the result in RESULT until the consumer takes it.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    lat_cnt_d = lat_cnt_q;
    count_d   = count_q;
    wrap_d    = wrap_q;
    count_inc = count_q + 4'd1;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          opnd_d    = bus.in_data;
          lat_cnt_d = LCW'(ADD_LAT);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt_q != '0) begin
          lat_cnt_d = lat_cnt_q - LCW'(1);
        end else begin
          // A sum smaller than the addend it was built on means the add wrapped.
          acc_d   = sum;
          wrap_d  = wrap_q | (sum < acc_q);
          count_d = count_inc;
          state_d = (count_inc == LAST) ? RESULT : IDLE;
        end
      end
      RESULT: begin
        if (bus.res_ready) begin
          acc_d   = '0;
          count_d = '0;
          wrap_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      opnd_q    <= '0;
      lat_cnt_q <= '0;
      count_q   <= '0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      lat_cnt_q <= lat_cnt_d;
      count_q   <= count_d;
      wrap_q    <= wrap_d;
    end
  end

  // Outputs decoded from registers; in_ready is also gated by reset.
  always_comb begin
    bus.in_ready  = (state_q == IDLE) && reset_n;
    bus.res_valid = (state_q == RESULT);
    bus.res_data  = acc_q;
    bus.res_wrap  = wrap_q;
    ain           = acc_q;
    bin           = opnd_q;
    busy          = (state_q != IDLE);
  end

endmodule

// File: tb/tb_add_accumulator.sv
// Self-checking bench for add_accumulator with a 1-cycle registered adder model.
module tb_add_accumulator;

  localparam int WIDTH   = 4;
  localparam int ADD_LAT = 1;
  localparam int N_WORDS = 4;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] ain, bin, sum;
  logic             busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;

  // Reference model: running total as plain integer arithmetic.
  int         exp_acc  = 0;
  logic       exp_wrap = 1'b0;
  logic [3:0] last_w   = '0;

  add_accumulator_if #(.WIDTH(WIDTH)) bus();

  add_accumulator #(
    .WIDTH  (WIDTH),
    .ADD_LAT(ADD_LAT),
    .N_WORDS(N_WORDS)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus),
    .ain    (ain),
    .bin    (bin),
    .sum    (sum),
    .busy   (busy)
  );

  // The team's 1-cycle adder.
  always @(posedge clock) sum <= ain + bin;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Present one word after gap idle cycles; returns the cycle of the accept edge.
  task automatic send_word(input logic [3:0] w, input int gap, output int unsigned acc_cyc);
    bit ok;
    ok = 0;
    acc_cyc = 0;
    repeat (gap) begin
      @(negedge clock);
      bus.in_valid = 1'b0;
    end
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (bus.in_ready) ok = 1;
      else @(negedge clock);
    end
    check("accept_timeout", 32'(ok), 32'd1);
    if (ok) begin
      @(posedge clock);
      #1;
      acc_cyc = cyc;
      check("bin_load", 32'(bin), 32'(w));
      check("busy_wait", 32'(busy), 32'd1);
      last_w = w;
    end
  endtask

  // Send a word, advance the model, and check the accumulator at the capture edge.
  task automatic feed_word(input logic [3:0] w, input int gap, input bit last,
                           output int unsigned acc_cyc);
    int nxt;
    send_word(w, gap, acc_cyc);
    nxt = exp_acc + int'(w);
    if (nxt >= 16) exp_wrap = 1'b1;
    exp_acc = nxt % 16;
    repeat (ADD_LAT) @(posedge clock);
    @(posedge clock);
    #1;
    check("ain_capture", 32'(ain), 32'(exp_acc));
    check("res_valid_after_capture", 32'(bus.res_valid), 32'(last));
  endtask

  // Check the held result under bp cycles of backpressure, then hand it off.
  task automatic collect_result(input int bp);
    check("res_data", 32'(bus.res_data), 32'(exp_acc));
    check("res_wrap", 32'(bus.res_wrap), 32'(exp_wrap));
    for (int i = 0; i < bp; i++) begin
      @(negedge clock);
      bus.in_valid = (i % 2 == 0);
      bus.in_data  = 4'($urandom);
      #1;
      check("in_ready_result", 32'(bus.in_ready), 32'd0);
      @(posedge clock);
      #1;
      check("bp_res_valid", 32'(bus.res_valid), 32'd1);
      check("bp_res_data", 32'(bus.res_data), 32'(exp_acc));
      check("bp_res_wrap", 32'(bus.res_wrap), 32'(exp_wrap));
      check("bp_bin_hold", 32'(bin), 32'(last_w));
    end
    @(negedge clock);
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clock);
    #1;
    check("post_hs_res_valid", 32'(bus.res_valid), 32'd0);
    check("post_hs_ain", 32'(ain), 32'd0);
    check("post_hs_busy", 32'(busy), 32'd0);
    exp_acc  = 0;
    exp_wrap = 1'b0;
    @(negedge clock);
    bus.res_ready = 1'b0;
    check("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  // One full batch; ws holds word 0 in its low nibble.
  task automatic run_batch(input logic [15:0] ws, input int max_gap, input int bp);
    int unsigned t, prev;
    int gap;
    prev = 0;
    for (int i = 0; i < N_WORDS; i++) begin
      gap = (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0));
      feed_word(ws[i*4 +: 4], gap, i == N_WORDS - 1, t);
      if (i > 0 && gap == 0) check("accept_spacing", t - prev, ADD_LAT + 2);
      prev = t;
    end
    collect_result(bp);
  endtask

  initial begin
    int unsigned t;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'hF;
    bus.res_ready = 1'b0;
    reset_n       = 1'b0;

    // Reset held with in_valid asserted: nothing may be accepted.
    repeat (3) begin
      @(posedge clock);
      #1;
      check("in_ready_in_reset", 32'(bus.in_ready), 32'd0);
      check("bin_in_reset", 32'(bin), 32'd0);
    end
    @(negedge clock);
    reset_n      = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_ain", 32'(ain), 32'd0);
    check("rst_bin", 32'(bin), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    check("rst_res_wrap", 32'(bus.res_wrap), 32'd0);

    // Directed batches.
    run_batch({4'h4, 4'h3, 4'h2, 4'h1}, 0, 0);
    run_batch({4'h0, 4'h1, 4'h9, 4'h7}, 0, 0);
    run_batch({4'h1, 4'h2, 4'h3, 4'h4}, 0, 5);
    run_batch({4'hF, 4'hF, 4'hF, 4'hF}, 0, 0);

    // Reset during WAIT of word 3 abandons the batch.
    feed_word(4'($urandom), 0, 1'b0, t);
    feed_word(4'($urandom), 0, 1'b0, t);
    send_word(4'($urandom), 0, t);
    @(negedge clock);
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clock);
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ain", 32'(ain), 32'd0);
    check("midrst_res_valid", 32'(bus.res_valid), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    exp_acc  = 0;
    exp_wrap = 1'b0;
    run_batch({4'h1, 4'h1, 4'h1, 4'h1}, 0, 0);

    // Gapped input.
    run_batch({4'h1, 4'h2, 4'h5, 4'h5}, 4, 0);

    // Random batches with random gaps and backpressure.
    for (int b = 0; b < 6; b++) begin
      run_batch(16'($urandom), 2, int'($urandom_range(3, 0)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
